i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Transmit end of the codec DAC path: accepts left/right 32-bit samples from the two processor cores over valid/ready streams and serialises them onto AUD_DACDAT in I2S format.
- The codec is bus master and drives AUD_BCLK and AUD_DACLRCK; this block only follows them.
- Per-channel FIFOs absorb core jitter. Underruns are counted.

Parameters:
- SAMPLE_W, 24, bits serialised per channel, MSB first; taken from data[SAMPLE_W-1:0].
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- aud_bclk  in  1  codec bit clock; asynchronous to clock; period at least 4 clock cycles.
- aud_daclrck  in  1  codec DAC word clock; 0 = left, 1 = right.
- aud_dacdat  out  1  serial DAC data.
- left_data  in  32  left sample.
- left_valid  in  1  left sample valid.
- left_ready  out  1  left FIFO can accept.
- right_data  in  32  right sample.
- right_valid  in  1  right sample valid.
- right_ready  out  1  right FIFO can accept.
- underrun_count  out  CNT_W  saturating count of channel slots loaded from an empty FIFO.

Behaviour:
- Reset (async assert, sync release):
  - aud_dacdat=0, both FIFOs empty, underrun_count=0.
  - Shift register 0, bit counter 0, armed=0.
  - *_ready=0 while reset is low.
- Synchronisers: aud_bclk and aud_daclrck each pass through 2 flops. Falling edge of BCLK (fe) = sync previous 1, current 0, detected one clock after the second flop.
- Handshake:
  - ready = !full.
  - Push on valid&&ready in any clock cycle.
  - Push on a full FIFO cannot occur, even if a pop happens in the same cycle (no pass-through).
- FIFO: count range 0..FIFO_DEPTH, with wrap-around of read/write pointers.
  - Push and pop in the same cycle on a non-empty FIFO leaves the count unchanged.
  - An empty FIFO with a simultaneous push and pop counts as an underrun; the pushed word stays queued.
- Framing, evaluated only on fe cycles:
  - lrck_prev holds the LRCK value captured at the previous fe.
  - First fe after reset: capture lrck_prev and set armed=1. No output yet.
  - armed and LRCK != lrck_prev:
    - Pop the FIFO for the new channel (LRCK 0 → left, 1 → right).
    - Load shreg with data[SAMPLE_W-1:0], or with the underrun value if the FIFO is empty.
    - Set bitcnt=SAMPLE_W. aud_dacdat stays at its current value.
  - Otherwise, if bitcnt>0: aud_dacdat <= shreg[SAMPLE_W-1], shreg <<= 1, bitcnt--.
  - Otherwise: aud_dacdat <= 0 (padding bits).
- Resulting timing:
  - MSB appears on the fe one BCLK after the LRCK transition, per I2S.
  - The LSB is the SAMPLE_W-th bit after that MSB.
- Short frame: an LRCK transition while bitcnt>0 reloads immediately. The remaining bits are dropped and there is no error.
- Underrun: when the popped channel FIFO is empty, underrun_count increments and saturates at all-ones.
- Reset mid-frame: everything returns to reset values. The block re-arms on the first fe after release and does not emit a partial word.
- aud_dacdat is registered. Latency from fe detection to the pin is 1 clock.

Optional Feature:
- Macro: I2S_DAC_TX_HOLD_LAST_EN.
- Defined: on underrun, load the last sample transmitted on that channel. The per-channel last-sample register resets to 0.
- Undefined: on underrun, load 0 (silence). No last-sample registers exist.
- Counting of underruns is identical in both cases.

Decomposition:
- Package i2s_pkg:
  - typedef chan_e {CH_LEFT=1'b0, CH_RIGHT=1'b1}.
  - Constant AUD_WORD_W=32.
  - Default SAMPLE_W and FIFO_DEPTH constants.
- Sub-module sample_fifo: parameterised synchronous FIFO, instantiated twice (left, right).
  - Ports: clock, reset, push, din, pop, dout, full, empty.

Test Plan:
- Reset, then BCLK=8 clock cycles per period, 32 BCLK per channel slot; push left 0x00ABCDEF and right 0x00123456 → left slot serialises 0xABCDEF MSB first, starting 1 BCLK after LRCK falls; right slot serialises 0x123456; 8 padding zeros per slot; underrun_count=0.
- Push 5 left words with no BCLK → left_ready deasserts after the 4th push; 5th word is not accepted; right_ready stays 1.
- BCLK running with no pushes for 3 full frames → aud_dacdat constantly 0; underrun_count=6 on the first LRCK transition of each slot after arming. With HOLD_LAST_EN after one left sample 0x7FFFFF: left slots repeat 0x7FFFFF.
- Preset underrun_count to 0xFFFE via continued starvation → counter reaches 0xFFFF and holds.
- Assert reset during bit 10 of a left word → aud_dacdat=0 within 1 clock; after release, no output until one fe plus one LRCK transition; the next word is serialised intact.
- LRCK toggles after only 16 BCLK → current word truncated after 15 data bits; next channel loads correctly; FIFO pops exactly once per transition.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and default sizes for the I2S DAC transmit path
package i2s_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  localparam int AUD_WORD_W     = 32;
  localparam int SAMPLE_W_DEF   = 24;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/i2s_dac_tx_sample_fifo.sv
// rtl/i2s_dac_tx_sample_fifo.sv - per-channel sample FIFO (first-word fall-through read port)
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC serialiser slaved to codec BCLK/LRCK; I2S_DAC_TX_HOLD_LAST_EN repeats the last sample on underrun
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_daclrck,
  output logic                  aud_dacdat,
  input  logic [AUD_WORD_W-1:0] left_data,
  input  logic                  left_valid,
  output logic                  left_ready,
  input  logic [AUD_WORD_W-1:0] right_data,
  input  logic                  right_valid,
  output logic                  right_ready,
  output logic [CNT_W-1:0]      underrun_count
);

  localparam int BC_W = $clog2(SAMPLE_W + 1);
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(SAMPLE_W);

  logic                r_bclk_s1;
  logic                r_bclk_s2;
  logic                r_bclk_prev;
  logic                r_lrck_s1;
  logic                r_lrck_s2;
  logic                r_lrck_prev;
  logic                r_armed;
  logic [SAMPLE_W-1:0] r_shreg;
  logic [BC_W-1:0]     r_bitcnt;
  logic                r_dacdat;
  logic [CNT_W-1:0]    r_underrun_cnt;

  logic                w_fe;
  logic                w_load;
  chan_e               w_chan;
  logic                w_l_full;
  logic                w_l_empty;
  logic                w_r_full;
  logic                w_r_empty;
  logic [SAMPLE_W-1:0] w_l_dout;
  logic [SAMPLE_W-1:0] w_r_dout;
  logic                w_sel_empty;
  logic [SAMPLE_W-1:0] w_sel_dout;
  logic [SAMPLE_W-1:0] w_underrun_val;
  logic [SAMPLE_W-1:0] w_word;

  if (SAMPLE_W < AUD_WORD_W) begin : g_hi_bits
    logic w_unused_hi;
    assign w_unused_hi = ^{left_data[AUD_WORD_W-1:SAMPLE_W], right_data[AUD_WORD_W-1:SAMPLE_W]};
  end

  // Codec clocks are asynchronous; both go through identical two-flop paths so they stay aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_prev <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
    end else begin
      r_bclk_s1   <= aud_bclk;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_prev <= r_bclk_s2;
      r_lrck_s1   <= aud_daclrck;
      r_lrck_s2   <= r_lrck_s1;
    end
  end

  assign w_fe   = r_bclk_prev && !r_bclk_s2;
  assign w_chan = chan_e'(r_lrck_s2);
  assign w_load = w_fe && r_armed && (r_lrck_s2 != r_lrck_prev);

  assign left_ready  = reset && !w_l_full;
  assign right_ready = reset && !w_r_full;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_left (
    .clock (clock),
    .reset (reset),
    .push  (left_valid && left_ready),
    .din   (left_data[SAMPLE_W-1:0]),
    .pop   (w_load && (w_chan == CH_LEFT)),
    .dout  (w_l_dout),
    .full  (w_l_full),
    .empty (w_l_empty)
  );

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_right (
    .clock (clock),
    .reset (reset),
    .push  (right_valid && right_ready),
    .din   (right_data[SAMPLE_W-1:0]),
    .pop   (w_load && (w_chan == CH_RIGHT)),
    .dout  (w_r_dout),
    .full  (w_r_full),
    .empty (w_r_empty)
  );

  assign w_sel_empty = (w_chan == CH_RIGHT) ? w_r_empty : w_l_empty;
  assign w_sel_dout  = (w_chan == CH_RIGHT) ? w_r_dout : w_l_dout;
  assign w_word      = w_sel_empty ? w_underrun_val : w_sel_dout;

`ifdef I2S_DAC_TX_HOLD_LAST_EN
  logic [SAMPLE_W-1:0] r_last_l;
  logic [SAMPLE_W-1:0] r_last_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_load && !w_sel_empty) begin
      if (w_chan == CH_RIGHT) begin
        r_last_r <= w_sel_dout;
      end else begin
        r_last_l <= w_sel_dout;
      end
    end
  end

  assign w_underrun_val = (w_chan == CH_RIGHT) ? r_last_r : r_last_l;
`else
  assign w_underrun_val = '0;
`endif

  // Load on the LRCK edge, then one bit per BCLK fall; the pin keeps its value on the load edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_armed        <= 1'b0;
      r_lrck_prev    <= 1'b0;
      r_shreg        <= '0;
      r_bitcnt       <= '0;
      r_dacdat       <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_fe) begin
      if (!r_armed) begin
        r_armed     <= 1'b1;
        r_lrck_prev <= r_lrck_s2;
      end else if (w_load) begin
        r_lrck_prev <= r_lrck_s2;
        r_shreg     <= w_word;
        r_bitcnt    <= BC_LOAD;
        if (w_sel_empty && (r_underrun_cnt != '1)) begin
          r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
      end else if (r_bitcnt != '0) begin
        r_dacdat <= r_shreg[SAMPLE_W-1];
        r_shreg  <= {r_shreg[SAMPLE_W-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - 1'b1;
      end else begin
        r_dacdat <= 1'b0;
      end
    end
  end

  assign aud_dacdat     = r_dacdat;
  assign underrun_count = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - self-checking bench for i2s_dac_tx against a slot-level I2S model
module tb_i2s_dac_tx;

  localparam int SW    = 24;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
  logic [31:0]   left_data;
  logic          left_valid;
  logic          left_ready;
  logic [31:0]   right_data;
  logic          right_valid;
  logic          right_ready;
  logic [CW-1:0] underrun_count;

  always #10 clock = ~clock;

  i2s_dac_tx #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .aud_bclk       (aud_bclk),
    .aud_daclrck    (aud_daclrck),
    .aud_dacdat     (aud_dacdat),
    .left_data      (left_data),
    .left_valid     (left_valid),
    .left_ready     (left_ready),
    .right_data     (right_data),
    .right_valid    (right_valid),
    .right_ready    (right_ready),
    .underrun_count (underrun_count)
  );

  typedef logic [SW-1:0] word_t;

  typedef struct {
    logic        ch;
    logic [31:0] data;
    logic        exp_l_rdy;
    logic        exp_r_rdy;
  } hs_vec_t;

  int          errors = 0;
  int          checks = 0;
  word_t       mq_l[$];
  word_t       mq_r[$];
  word_t       m_last_l;
  word_t       m_last_r;
  int          m_uc;
  logic        m_bit;
  logic [63:0] cap;
  hs_vec_t     tab[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq_l.delete();
    mq_r.delete();
    m_last_l = '0;
    m_last_r = '0;
    m_uc     = 0;
    m_bit    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b0;
    aud_bclk    = 1'b1;
    left_valid  = 1'b0;
    right_valid = 1'b0;
    model_reset();
    @(negedge clock);
    chk("reset_ready", {left_ready, right_ready}, 2'b00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // One BCLK period per bit: fall (with LRCK update), 4 clocks low, 4 high, sample before next fall.
  task automatic play(input logic lr, input int n);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      aud_bclk    = 1'b0;
      aud_daclrck = lr;
      repeat (4) @(negedge clock);
      aud_bclk = 1'b1;
      repeat (4) @(negedge clock);
      cap[i] = aud_dacdat;
    end
  endtask

  task automatic push(input logic ch, input logic [31:0] d);
    logic exp_rdy;
    @(negedge clock);
    if (ch) begin
      right_valid = 1'b1;
      right_data  = d;
      exp_rdy     = (mq_r.size() < DEPTH);
      chk("push_r_ready", right_ready, exp_rdy);
      if (exp_rdy) mq_r.push_back(d[SW-1:0]);
    end else begin
      left_valid = 1'b1;
      left_data  = d;
      exp_rdy    = (mq_l.size() < DEPTH);
      chk("push_l_ready", left_ready, exp_rdy);
      if (exp_rdy) mq_l.push_back(d[SW-1:0]);
    end
    @(posedge clock);
    #1;
    left_valid  = 1'b0;
    right_valid = 1'b0;
  endtask

  task automatic arm(input logic lr, input int n);
    play(lr, n);
    chk("arm_silent", cap, 64'd0);
    m_bit = 1'b0;
  endtask

  // Expected slot: bit 0 holds the previous pin value, bits 1..SW are the word MSB first, rest zero.
  task automatic slot(input string name, input logic lr, input int n);
    word_t       w;
    logic [63:0] e;
    if (lr && mq_r.size() > 0) begin
      w        = mq_r.pop_front();
      m_last_r = w;
    end else if (!lr && mq_l.size() > 0) begin
      w        = mq_l.pop_front();
      m_last_l = w;
    end else begin
`ifdef I2S_DAC_TX_HOLD_LAST_EN
      w = lr ? m_last_r : m_last_l;
`else
      w = '0;
`endif
      if (m_uc < (1 << CW) - 1) m_uc++;
    end
    e    = '0;
    e[0] = m_bit;
    for (int j = 1; j < n; j++) begin
      e[j] = (j <= SW) ? w[SW-j] : 1'b0;
    end
    play(lr, n);
    chk(name, cap, e);
    chk({name, "_uc"}, underrun_count, m_uc);
    m_bit = e[n-1];
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    aud_bclk    = 1'b1;
    aud_daclrck = 1'b1;
    left_valid  = 1'b0;
    right_valid = 1'b0;
    left_data   = '0;
    right_data  = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_dacdat", aud_dacdat, 0);
    chk("reset_uc", underrun_count, 0);
    chk("reset_ready_low", {left_ready, right_ready}, 2'b00);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("ready_after_release", {left_ready, right_ready}, 2'b11);

    // Basic stereo frame
    push(1'b0, 32'h00ABCDEF);
    push(1'b1, 32'h00123456);
    arm(1'b1, 2);
    slot("basic_l", 1'b0, 32);
    slot("basic_r", 1'b1, 32);
    chk("basic_uc_zero", underrun_count, 0);

    // FIFO fill with BCLK idle
    do_reset();
    for (int i = 0; i < 5; i++) tab[i] = '{1'b0, $urandom, (i < 4), 1'b1};
    tab[5] = '{1'b1, $urandom, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (tab[i].ch) begin
        right_valid = 1'b1;
        right_data  = tab[i].data;
      end else begin
        left_valid = 1'b1;
        left_data  = tab[i].data;
      end
      chk("fill_l_ready", left_ready, tab[i].exp_l_rdy);
      chk("fill_r_ready", right_ready, tab[i].exp_r_rdy);
      if (tab[i].ch && mq_r.size() < DEPTH) mq_r.push_back(tab[i].data[SW-1:0]);
      if (!tab[i].ch && mq_l.size() < DEPTH) mq_l.push_back(tab[i].data[SW-1:0]);
      @(posedge clock);
      #1;
      left_valid  = 1'b0;
      right_valid = 1'b0;
    end
    arm(1'b1, 2);
    for (int k = 0; k < 5; k++) begin
      slot("drain_l", 1'b0, 28);
      slot("drain_r", 1'b1, 28);
    end

    // Starvation
    do_reset();
    arm(1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      slot("starve_l", 1'b0, 32);
      slot("starve_r", 1'b1, 32);
    end
    chk("starve_uc_six", underrun_count, 6);
    push(1'b0, 32'h007FFFFF);
    for (int k = 0; k < 2; k++) begin
      slot("hold_l", 1'b0, 32);
      slot("hold_r", 1'b1, 32);
    end

    // Short frame: LRCK toggles after 16 BCLK
    do_reset();
    push(1'b0, 32'h00C3A55A);
    push(1'b0, 32'h00F0F00F);
    push(1'b1, 32'h00BEEF01);
    arm(1'b1, 2);
    slot("short_l", 1'b0, 16);
    slot("short_r", 1'b1, 32);
    slot("short_l2", 1'b0, 32);
    slot("short_r2", 1'b1, 8);

    // Reset during bit 10 of a left word
    do_reset();
    push(1'b0, 32'h00FFC000);
    arm(1'b1, 2);
    play(1'b0, 11);
    chk("mid_bits", cap, 64'h7FE);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_reset_dacdat", aud_dacdat, 0);
    chk("mid_reset_ready", {left_ready, right_ready}, 2'b00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clock);
    push(1'b1, 32'h005A5A5A);
    arm(1'b0, 4);
    slot("post_reset_r", 1'b1, 32);
    slot("post_reset_l", 1'b0, 32);

    // Randomized traffic with random slot lengths
    do_reset();
    arm(1'b1, 2);
    for (int k = 0; k < 16; k++) begin
      int nl;
      int nr;
      nl = $urandom_range(0, 3);
      nr = $urandom_range(0, 3);
      for (int p = 0; p < nl; p++) push(1'b0, $urandom);
      for (int p = 0; p < nr; p++) push(1'b1, $urandom);
      slot("rand_l", 1'b0, $urandom_range(4, 34));
      slot("rand_r", 1'b1, $urandom_range(4, 34));
    end

    // Counter saturation
    do_reset();
    arm(1'b1, 2);
    for (int k = 0; k < 9; k++) begin
      slot("sat_l", 1'b0, 4);
      slot("sat_r", 1'b1, 4);
    end
    chk("sat_hold", underrun_count, (1 << CW) - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
